// File: rtl/srt_div_pkg.sv
// Shared definitions for the SRT divider back end.
//   EXP_W_D / MAN_W_D : default exponent and stored-mantissa widths
//   RES_W_D / SHIFT_W_D : derived raw-quotient and pre-shift widths
//   fp_word_t : packed IEEE-754 word {sign, exp, man}
//   flags_t   : exception flags {overflow, underflow, inexact}
package srt_div_pkg;

  localparam int EXP_W_D   = 8;
  localparam int MAN_W_D   = 23;
  localparam int RES_W_D   = MAN_W_D + 3;
  localparam int SHIFT_W_D = $clog2(RES_W_D + 1);

  localparam logic [EXP_W_D-1:0] EXP_MAX_C  = '1;
  localparam int                 EXP_BIAS_C = (1 << (EXP_W_D - 1)) - 1;

  typedef struct packed {
    logic               sign;
    logic [EXP_W_D-1:0] exp;
    logic [MAN_W_D-1:0] man;
  } fp_word_t;

  typedef struct packed {
    logic overflow;
    logic underflow;
    logic inexact;
  } flags_t;

endpackage

// File: rtl/srt_lzc.sv
// Leading-zero counter.
//   d        : input word, counted from bit W-1 downwards
//   count    : number of leading zeros (W when d is all zero)
//   all_zero : d == 0
module srt_lzc
  import srt_div_pkg::*;
#(
  parameter int W     = RES_W_D,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     d,
  output logic [CNT_W-1:0] count,
  output logic             all_zero
);

  // Scan upwards so the most significant set bit is the last one to win.
  always_comb begin
    count = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      if (d[i]) count = CNT_W'(W - 1 - i);
    end
  end

  assign all_zero = ~|d;

endmodule

// File: rtl/srt_quotient_normalizer.sv
// SRT divider back end: pre-shift, normalise, round-to-nearest-even, pack.
// Two-stage pipeline with valid/ready on both sides, one result per cycle.
//   clk, rst_n        : clock, asynchronous active-low reset
//   in_valid/in_ready : input handshake
//   in_result         : raw quotient {hidden, mantissa, guard, round}
//   in_shift, in_right_shift : pre-shift amount and direction
//   in_sign, in_exponent, in_sticky : sign, biased exponent, remainder nonzero
//   out_valid/out_ready : output handshake
//   out_quotient      : packed {sign, exponent, mantissa}
//   out_overflow/out_underflow/out_inexact : exception flags
module srt_quotient_normalizer
  import srt_div_pkg::*;
#(
  parameter int EXP_W   = EXP_W_D,
  parameter int MAN_W   = MAN_W_D,
  parameter int RES_W   = MAN_W + 3,
  parameter int SHIFT_W = $clog2(RES_W + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [RES_W-1:0]       in_result,
  input  logic [SHIFT_W-1:0]     in_shift,
  input  logic                   in_right_shift,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exponent,
  input  logic                   in_sticky,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_quotient,
  output logic                   out_overflow,
  output logic                   out_underflow,
  output logic                   out_inexact
);

  localparam int EW = EXP_W + 2;

  typedef struct packed {
    logic [EXP_W+MAN_W:0] word;
    flags_t               flags;
  } rp_t;

  function automatic rp_t round_pack(
    input logic [RES_W-1:0]     n,
    input logic signed [EW-1:0] e,
    input logic                 s,
    input logic                 sign,
    input logic                 zero
  );
    rp_t                 r;
    logic                lsb, g, rb, up;
    logic [MAN_W+1:0]    sig;
    logic signed [EW-1:0] e_r;
    lsb = n[2];
    g   = n[1];
    rb  = n[0];
    up  = g & (rb | s | lsb);
    // Significand including the hidden bit; a carry past the hidden bit
    // leaves the stored mantissa at zero and bumps the exponent.
    sig = {1'b0, n[RES_W-1:2]} + {{(MAN_W + 1){1'b0}}, up};
    e_r = (sig[MAN_W+1:MAN_W] == 2'b10) ? e + EW'(1) : e;
    r   = '0;
    if (zero) begin
      r.word          = {sign, {(EXP_W + MAN_W){1'b0}}};
      r.flags.inexact = s;
    end else if (e_r >= $signed({2'b00, {EXP_W{1'b1}}})) begin
      r.word           = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      r.flags.overflow = 1'b1;
      r.flags.inexact  = 1'b1;
    end else if (e_r <= $signed(EW'(0))) begin
      r.word            = {sign, {(EXP_W + MAN_W){1'b0}}};
      r.flags.underflow = 1'b1;
      r.flags.inexact   = 1'b1;
    end else begin
      r.word          = {sign, e_r[EXP_W-1:0], sig[MAN_W-1:0]};
      r.flags.inexact = g | rb | s;
    end
    return r;
  endfunction

  logic adv1, adv2;
  logic vld_p1, vld_p2;

  logic [RES_W-1:0]     t, lost, n;
  logic                 sticky;
  logic [SHIFT_W-1:0]   lz;
  logic                 all_zero;
  logic signed [EW-1:0] e;

  logic [RES_W-1:0]     n_p1;
  logic signed [EW-1:0] e_p1;
  logic                 sticky_p1, sign_p1, zero_p1;
  rp_t                  rp_p2;

  assign adv2     = !vld_p2 | out_ready;
  assign adv1     = !vld_p1 | adv2;
  assign in_ready = adv1;

  // Stage 0 -> 1: pre-shift, leading-zero count, normalise
  always_comb begin
    t      = '0;
    lost   = '0;
    sticky = in_sticky;
    if (in_shift >= SHIFT_W'(RES_W)) begin
      if (in_right_shift) sticky = in_sticky | (|in_result);
    end else if (in_right_shift) begin
      t      = in_result >> in_shift;
      lost   = in_result & ~({RES_W{1'b1}} << in_shift);
      sticky = in_sticky | (|lost);
    end else begin
      t = in_result << in_shift;
    end
  end

  srt_lzc #(.W(RES_W), .CNT_W(SHIFT_W)) u_lzc (
    .d        (t),
    .count    (lz),
    .all_zero (all_zero)
  );

  assign n = t << lz;
  assign e = $signed({2'b00, in_exponent}) - $signed({{(EW - SHIFT_W){1'b0}}, lz});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      n_p1      <= '0;
      e_p1      <= '0;
      sticky_p1 <= 1'b0;
      sign_p1   <= 1'b0;
      zero_p1   <= 1'b0;
    end else if (adv1) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        n_p1      <= n;
        e_p1      <= e;
        sticky_p1 <= sticky;
        sign_p1   <= in_sign;
        zero_p1   <= all_zero;
      end
    end
  end

  // Stage 1 -> 2: round, exception select, pack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      rp_p2  <= '0;
    end else if (adv2) begin
      vld_p2 <= vld_p1;
      if (vld_p1) rp_p2 <= round_pack(n_p1, e_p1, sticky_p1, sign_p1, zero_p1);
    end
  end

  assign out_valid     = vld_p2;
  assign out_quotient  = rp_p2.word;
  assign out_overflow  = rp_p2.flags.overflow;
  assign out_underflow = rp_p2.flags.underflow;
  assign out_inexact   = rp_p2.flags.inexact;

endmodule
